// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The arbiter connects through the master modport; the environment that
// plays requesters and memory connects through the slave modport.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  m0_req_in;
   logic                  m1_req_in;
   logic                  m0_write_in;
   logic                  m1_write_in;
   logic [DATA_WIDTH-1:0] m0_addr_in;
   logic [DATA_WIDTH-1:0] m1_addr_in;
   logic [DATA_WIDTH-1:0] m0_wdata_in;
   logic [DATA_WIDTH-1:0] m1_wdata_in;
   logic                  m0_ack_out;
   logic                  m1_ack_out;
   logic [DATA_WIDTH-1:0] m0_rdata_out;
   logic [DATA_WIDTH-1:0] m1_rdata_out;
   logic                  mem_enable_out;
   logic                  mem_write_out;
   logic [DATA_WIDTH-1:0] mem_addr_out;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic                  mem_ready_in;
   logic [DATA_WIDTH-1:0] mem_data_in;

   modport master (
      input  m0_req_in, m1_req_in, m0_write_in, m1_write_in,
      input  m0_addr_in, m1_addr_in, m0_wdata_in, m1_wdata_in,
      output m0_ack_out, m1_ack_out, m0_rdata_out, m1_rdata_out,
      output mem_enable_out, mem_write_out, mem_addr_out, mem_data_out,
      input  mem_ready_in, mem_data_in
   );

   modport slave (
      output m0_req_in, m1_req_in, m0_write_in, m1_write_in,
      output m0_addr_in, m1_addr_in, m0_wdata_in, m1_wdata_in,
      input  m0_ack_out, m1_ack_out, m0_rdata_out, m1_rdata_out,
      input  mem_enable_out, mem_write_out, mem_addr_out, mem_data_out,
      output mem_ready_in, mem_data_in
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Each access walks IDLE -> ACCESS (wait states while memory not ready)
// -> ACK, so at most one access completes every three cycles.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input logic           clk_in,
   input logic           rst_n_in,
   mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic                  grant_reg, grant_next;
   logic                  last_grant_reg, last_grant_next;
   logic                  write_reg, write_next;
   logic [DATA_WIDTH-1:0] addr_reg, addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;

   logic [1:0]            req_vec;
   logic [1:0]            write_vec;
   logic [DATA_WIDTH-1:0] addr_arr  [2];
   logic [DATA_WIDTH-1:0] wdata_arr [2];
   logic [DATA_WIDTH-1:0] rdata_arr [2];
   logic [1:0]            ack_vec;
   logic [1:0]            capture_vec;
   logic                  win;
   logic                  read_done;
   logic                  mem_enable;
   logic                  mem_write;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;

   // Requester inputs gathered into indexable form so the winner can be muxed
   assign req_vec      = {bus.m1_req_in, bus.m0_req_in};
   assign write_vec    = {bus.m1_write_in, bus.m0_write_in};
   assign addr_arr[0]  = bus.m0_addr_in;
   assign addr_arr[1]  = bus.m1_addr_in;
   assign wdata_arr[0] = bus.m0_wdata_in;
   assign wdata_arr[1] = bus.m1_wdata_in;

   // State and latched winner request; last grant starts at 1 so m0 wins the first tie
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         write_reg      <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         write_reg      <= write_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
      end
   end

   // Next state, arbitration and memory/ack outputs decoded from the current state
   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      write_next      = write_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      win             = 1'b0;
      read_done       = 1'b0;
      ack_vec         = 2'b00;
      mem_enable      = 1'b0;
      mem_write       = 1'b0;
      mem_addr        = '0;
      mem_data        = '0;
      case (state_reg)
         IDLE: begin
            if (|req_vec) begin
               // m1 wins when alone, or on a tie when m0 was granted last
               win             = req_vec[1] & (~req_vec[0] | ~last_grant_reg);
               grant_next      = win;
               last_grant_next = win;
               write_next      = write_vec[win];
               addr_next       = addr_arr[win];
               wdata_next      = wdata_arr[win];
               state_next      = ACCESS;
            end
         end
         ACCESS: begin
            mem_enable = 1'b1;
            mem_write  = write_reg;
            mem_addr   = addr_reg;
            mem_data   = wdata_reg;
            // Anything other than a clean 1 (including X/Z) is treated as a wait state
            if (bus.mem_ready_in == 1'b1) begin
               state_next = ACK;
               read_done  = ~write_reg;
            end
         end
         ACK: begin
            ack_vec[grant_reg] = 1'b1;
            state_next         = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      logic [DATA_WIDTH-1:0] rdata_reg;

      assign capture_vec[gi] = read_done && (int'(grant_reg) == gi);

      // Read data register changes only when this requester's read completes
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            rdata_reg <= '0;
         end else if (capture_vec[gi]) begin
            rdata_reg <= bus.mem_data_in;
         end
      end

      assign rdata_arr[gi] = rdata_reg;
   end

   assign bus.m0_ack_out     = ack_vec[0];
   assign bus.m1_ack_out     = ack_vec[1];
   assign bus.m0_rdata_out   = rdata_arr[0];
   assign bus.m1_rdata_out   = rdata_arr[1];
   assign bus.mem_enable_out = mem_enable;
   assign bus.mem_write_out  = mem_write;
   assign bus.mem_addr_out   = mem_addr;
   assign bus.mem_data_out   = mem_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random requesters and random memory wait states, all checked each cycle
// against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;
   logic clk_in;
   logic rst_n_in;
   int   total = 0;
   int   bad   = 0;

   mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   mem_arbiter #(.DATA_WIDTH(32)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // memory seen by the DUT and the shadow copy owned by the model
   logic [31:0] tb_mem  [256];
   logic [31:0] ref_mem [256];
   assign bus.mem_data_in = tb_mem[bus.mem_addr_out[7:0]];

   // model: one transaction in flight at most
   bit          m_busy;
   bit          m_done;
   bit          m_owner;
   bit          m_last;
   bit          m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process plus model advance, once per cycle on the falling edge
   initial begin
      bit          exp_en;
      bit          exp_ack0;
      bit          exp_ack1;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      bit          exp_we;
      forever begin
         @(negedge clk_in);
         if (!rst_n_in) begin
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_last     = 1'b1;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
         end
         exp_en   = m_busy && !m_done;
         exp_we   = exp_en && m_we;
         exp_addr = exp_en ? m_addr : 32'd0;
         exp_data = exp_en ? m_wdata : 32'd0;
         exp_ack0 = m_done && (m_owner == 1'b0);
         exp_ack1 = m_done && (m_owner == 1'b1);
         chk("mem_enable", 32'(bus.mem_enable_out), 32'(exp_en));
         chk("mem_write", 32'(bus.mem_write_out), 32'(exp_we));
         chk("mem_addr", bus.mem_addr_out, exp_addr);
         chk("mem_data", bus.mem_data_out, exp_data);
         chk("m0_ack", 32'(bus.m0_ack_out), 32'(exp_ack0));
         chk("m1_ack", 32'(bus.m1_ack_out), 32'(exp_ack1));
         chk("m0_rdata", bus.m0_rdata_out, m_rdata[0]);
         chk("m1_rdata", bus.m1_rdata_out, m_rdata[1]);
         if (rst_n_in) begin
            // memory side: a write lands when enabled, writing and ready
            if (bus.mem_enable_out && bus.mem_write_out && bus.mem_ready_in === 1'b1)
               tb_mem[bus.mem_addr_out[7:0]] = bus.mem_data_out;
            if (m_done) begin
               m_busy = 1'b0;
               m_done = 1'b0;
            end else if (m_busy) begin
               if (bus.mem_ready_in === 1'b1) begin
                  m_done = 1'b1;
                  if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                  else      m_rdata[m_owner] = ref_mem[m_addr[7:0]];
                  $display("txn m%0d %s addr=%h data=%h", m_owner, m_we ? "write" : "read",
                           m_addr, m_we ? m_wdata : ref_mem[m_addr[7:0]]);
               end
            end else if (bus.m0_req_in || bus.m1_req_in) begin
               if (bus.m0_req_in && bus.m1_req_in) m_owner = !m_last;
               else                                m_owner = bus.m1_req_in;
               m_last  = m_owner;
               m_busy  = 1'b1;
               m_we    = m_owner ? bus.m1_write_in : bus.m0_write_in;
               m_addr  = m_owner ? bus.m1_addr_in  : bus.m0_addr_in;
               m_wdata = m_owner ? bus.m1_wdata_in : bus.m0_wdata_in;
            end
         end
      end
   end

   task automatic set_req(input int id, input bit r, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
      if (id == 0) begin
         bus.m0_req_in = r; bus.m0_write_in = we; bus.m0_addr_in = a; bus.m0_wdata_in = d;
      end else begin
         bus.m1_req_in = r; bus.m1_write_in = we; bus.m1_addr_in = a; bus.m1_wdata_in = d;
      end
   endtask

   function automatic bit get_ack(input int id);
      return (id == 0) ? bus.m0_ack_out : bus.m1_ack_out;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // issue one request and hold it until its ack (bounded)
   task automatic do_req(input int id, input bit we, input logic [31:0] a,
                         input logic [31:0] d, output int cyc, output int en_cnt);
      bit got;
      got    = 1'b0;
      cyc    = 0;
      en_cnt = 0;
      set_req(id, 1'b1, we, a, d);
      for (int k = 0; k < 30 && !got; k++) begin
         step();
         cyc++;
         if (bus.mem_enable_out) en_cnt++;
         if (get_ack(id)) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL ack_timeout: m%0d got no ack required one within 30 cycles", id);
      end
      set_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      int          cyc;
      int          en_cnt;
      int          n;
      int          overlap;
      int          extra;
      int          order [4];
      bit          got;
      logic [31:0] v;

      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         tb_mem[i]  = v;
         ref_mem[i] = v;
      end
      tb_mem[16]  = 32'hDEADBEEF;
      ref_mem[16] = 32'hDEADBEEF;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      bus.mem_ready_in = 1'b1;
      rst_n_in = 1'b0;
      repeat (3) step();
      chk("reset_enable", 32'(bus.mem_enable_out), 32'd0);
      chk("reset_ack0", 32'(bus.m0_ack_out), 32'd0);
      chk("reset_rdata0", bus.m0_rdata_out, 32'd0);
      chk("reset_rdata1", bus.m1_rdata_out, 32'd0);
      rst_n_in = 1'b1;

      // m0 read of 0x10
      do_req(0, 1'b0, 32'h10, 32'd0, cyc, en_cnt);
      chk("r027_latency", 32'(cyc), 32'd2);
      chk("r027_enable_cycles", 32'(en_cnt), 32'd1);
      chk("r027_rdata", bus.m0_rdata_out, 32'hDEADBEEF);
      step();

      // m1 write then read back
      do_req(1, 1'b1, 32'h4, 32'h12345678, cyc, en_cnt);
      chk("r028_write_cycles", 32'(en_cnt), 32'd1);
      chk("r028_rdata_after_write", bus.m1_rdata_out, 32'd0);
      step();
      do_req(1, 1'b0, 32'h4, 32'd0, cyc, en_cnt);
      chk("r028_readback", bus.m1_rdata_out, 32'h12345678);
      chk("r028_m0_untouched", bus.m0_rdata_out, 32'hDEADBEEF);
      step();

      // wait states: ready low for three edges in ACCESS
      bus.mem_ready_in = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h4, 32'd0);
      step();
      for (int k = 0; k < 3; k++) begin
         chk("r030_hold_enable", 32'(bus.mem_enable_out), 32'd1);
         chk("r030_hold_addr", bus.mem_addr_out, 32'h4);
         chk("r030_no_ack", 32'(bus.m0_ack_out), 32'd0);
         step();
      end
      bus.mem_ready_in = 1'b1;
      step();
      chk("r030_ack", 32'(bus.m0_ack_out), 32'd1);
      chk("r030_rdata", bus.m0_rdata_out, 32'h12345678);
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      step();

      // reset in the middle of an access
      bus.mem_ready_in = 1'b0;
      set_req(1, 1'b1, 1'b0, 32'h10, 32'd0);
      step();
      chk("r031_in_access", 32'(bus.mem_enable_out), 32'd1);
      rst_n_in = 1'b0;
      #1;
      chk("r031_enable_drop", 32'(bus.mem_enable_out), 32'd0);
      chk("r031_ack1_low", 32'(bus.m1_ack_out), 32'd0);
      chk("r031_rdata0", bus.m0_rdata_out, 32'd0);
      chk("r031_rdata1", bus.m1_rdata_out, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      bus.mem_ready_in = 1'b1;
      step();
      rst_n_in = 1'b1;

      // both requests held: strict alternation starting with m0
      set_req(0, 1'b1, 1'b0, 32'h10, 32'd0);
      set_req(1, 1'b1, 1'b0, 32'h4, 32'd0);
      n = 0;
      overlap = 0;
      for (int k = 0; k < 40 && n < 4; k++) begin
         step();
         if (bus.m0_ack_out && bus.m1_ack_out) overlap++;
         if (bus.m0_ack_out)      begin order[n] = 0; n++; end
         else if (bus.m1_ack_out) begin order[n] = 1; n++; end
      end
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("r029_ack_count", 32'(n), 32'd4);
      chk("r029_overlap", 32'(overlap), 32'd0);
      chk("r029_grant0", 32'(order[0]), 32'd0);
      chk("r029_grant1", 32'(order[1]), 32'd1);
      chk("r029_grant2", 32'(order[2]), 32'd0);
      chk("r029_grant3", 32'(order[3]), 32'd1);
      chk("r029_rdata0", bus.m0_rdata_out, 32'hDEADBEEF);
      chk("r029_rdata1", bus.m1_rdata_out, 32'h12345678);
      step();

      // m0 raises req during m1's ack cycle
      set_req(1, 1'b1, 1'b1, 32'h9, 32'hA5A5A5A5);
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         step();
         if (bus.m1_ack_out) got = 1'b1;
      end
      chk("r032_m1_acked", 32'(got), 32'd1);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(0, 1'b1, 1'b0, 32'h9, 32'd0);
      got   = 1'b0;
      cyc   = 0;
      extra = 0;
      for (int k = 0; k < 30 && !got; k++) begin
         step();
         cyc++;
         if (bus.m1_ack_out) extra++;
         if (bus.m0_ack_out) got = 1'b1;
      end
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("r032_m0_latency", 32'(cyc), 32'd3);
      chk("r032_no_dup_ack", 32'(extra), 32'd0);
      chk("r032_rdata", bus.m0_rdata_out, 32'hA5A5A5A5);
      step();

      // random traffic and random wait states
      for (int c = 0; c < 3000; c++) begin
         step();
         if (bus.m0_req_in) begin
            if (bus.m0_ack_out) set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
         end else if ($urandom_range(0, 2) == 0) begin
            set_req(0, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 32'd0);
            set_req(0, 1'b1, bus.m0_req_in, 32'($urandom_range(0, 15)), $urandom);
         end
         if (bus.m1_req_in) begin
            if (bus.m1_ack_out) set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
         end else if ($urandom_range(0, 2) == 0) begin
            set_req(1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
         end
         bus.mem_ready_in = ($urandom_range(0, 3) != 0);
      end
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      bus.mem_ready_in = 1'b1;
      repeat (8) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of every address and data bus.
REQ-002 clk_in  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n_in  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 m0_req_in / m1_req_in  input  1  SHALL be the per-requester access requests.
REQ-005 m0_write_in / m1_write_in  input  1  SHALL select write (1) or read (0) per requester.
REQ-006 m0_addr_in / m1_addr_in  input  DATA_WIDTH  SHALL be the per-requester word address.
REQ-007 m0_wdata_in / m1_wdata_in  input  DATA_WIDTH  SHALL be the per-requester write data.
REQ-008 m0_ack_out / m1_ack_out  output  1  SHALL be a one-cycle completion pulse per requester.
REQ-009 m0_rdata_out / m1_rdata_out  output  DATA_WIDTH  SHALL be the registered read data per requester.
REQ-010 mem_enable_out, mem_write_out  output  1  SHALL drive the memory port enable and write.
REQ-011 mem_addr_out, mem_data_out  output  DATA_WIDTH  SHALL drive the memory address and write data.
REQ-012 mem_ready_in  input  1, mem_data_in  input  DATA_WIDTH  SHALL be the memory ready flag and combinational read data.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS, ACK.
REQ-014 In IDLE with no request asserted, the FSM SHALL stay in IDLE; all memory outputs SHALL be 0.
REQ-015 In IDLE with one or both requests asserted, the FSM SHALL latch grant, write, addr and wdata of the winner and go to ACCESS.
REQ-016 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not granted last wins; last_grant SHALL update only on entry to ACCESS.
REQ-017 In ACCESS, mem_enable_out SHALL be 1; mem_write_out, mem_addr_out and mem_data_out SHALL carry the latched values; they SHALL be 0 in every other state.
REQ-018 In ACCESS with mem_ready_in=1, the FSM SHALL go to ACK and, on a read, capture mem_data_in into the winner's rdata register at that edge.
REQ-019 In ACCESS with mem_ready_in!=1 (0, X or Z), the FSM SHALL stay in ACCESS (wait state) with outputs held.
REQ-020 In ACK, the winner's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0; the next state SHALL be IDLE.
REQ-021 Best-case latency SHALL be 3 cycles (req sampled -> ack high 2 edges later), giving at most one access per 3 cycles.
REQ-022 Requests SHALL be level-sensitive; a requester SHALL hold req/write/addr/wdata stable until its ack and deassert req by the edge ending its ack cycle; a req still high in IDLE is a new request.
REQ-023 rdata registers SHALL change only on a read completion for that requester; writes SHALL leave both unchanged.
REQ-024 Request inputs SHALL be ignored outside IDLE; a losing or late requester SHALL be served on the next IDLE evaluation.

Reset
REQ-025 While rst_n_in=0, state SHALL be IDLE, last_grant SHALL be 1 (m0 wins first tie), and all outputs including rdata SHALL be 0, asynchronously.
REQ-026 Reset asserted in ACCESS or ACK SHALL drop mem_enable_out and acks immediately; the interrupted access SHALL not be acked or retried.

Verification
REQ-027 m0 read addr 0x10, memory word 0x10 = 0xDEADBEEF -> mem_enable_out high 1 cycle, m0_ack_out pulse 2 edges after req sampled, m0_rdata_out=0xDEADBEEF.
REQ-028 m1 write addr 0x4 data 0x12345678 then m1 read 0x4 -> one write cycle with mem_write_out=1, read returns 0x12345678, m1_rdata_out unchanged by the write.
REQ-029 Both req held continuously after reset, 4 accesses -> grant order m0,m1,m0,m1, acks never overlap.
REQ-030 mem_ready_in held 0 for 3 cycles in ACCESS -> FSM stays in ACCESS with stable address, ack one cycle after ready rises.
REQ-031 rst_n_in pulsed low mid-ACCESS -> mem_enable_out and acks 0 immediately, rdata 0, next tie after reset granted to m0.
REQ-032 m0 req in ACK cycle of m1 -> ignored until IDLE, then served; no lost or duplicate acks.
